// File: rtl/t5_ifetch_dec.sv
// Instruction-fetch response and decode stage for the 4-hart barrel pipeline.
// Registers one instruction per enabled cycle; a 1-entry skid absorbs acks that land while stalled.
module t5_ifetch_dec #(
    parameter int          XLEN = 32,
    parameter logic [31:0] NOP  = 32'h0000_0013
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [XLEN-1:0] fpc,
    input  logic [XLEN-1:0] iwb_dat,
    input  logic            iwb_ack,
    output logic [XLEN-1:0] dinst,
    output logic [29:0]     dpc,
    output logic [1:0]      dtag,
    output logic            dvld,
    output logic            dill,
    output logic [4:0]      dopc,
    output logic [2:0]      dfn3,
    output logic            dfn7,
    output logic [4:0]      drd,
    output logic [4:0]      drs1,
    output logic [4:0]      drs2,
    output logic [XLEN-1:0] dimm
);

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_MISC   = 5'b00011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    logic [31:0] dinst_q, dinst_d;
    logic [29:0] dpc_q, dpc_d;
    logic [1:0]  dtag_q, dtag_d;
    logic        dvld_q, dvld_d;
    logic [31:0] skid_q, skid_d;
    logic        skid_full_q, skid_full_d;

    always_comb begin
        dinst_d     = dinst_q;
        dpc_d       = dpc_q;
        dtag_d      = dtag_q;
        dvld_d      = dvld_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (sena) begin
            dpc_d  = fpc[31:2];
            dtag_d = fpc[1:0];
            if (skid_full_q) begin
                // Drain the skid first; a same-cycle ack refills it so nothing is lost.
                dinst_d     = skid_q;
                dvld_d      = 1'b1;
                skid_full_d = iwb_ack;
                if (iwb_ack) begin
                    skid_d = iwb_dat;
                end
            end else if (iwb_ack) begin
                dinst_d = iwb_dat;
                dvld_d  = 1'b1;
            end else begin
                dinst_d = NOP;
                dvld_d  = 1'b0;
            end
        end else if (iwb_ack) begin
            skid_d      = iwb_dat;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            dinst_q     <= NOP;
            dpc_q       <= '0;
            dtag_q      <= '0;
            dvld_q      <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            dinst_q     <= dinst_d;
            dpc_q       <= dpc_d;
            dtag_q      <= dtag_d;
            dvld_q      <= dvld_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end

    // Decode is taken from the registered instruction, so outputs depend on flops only.
    logic [4:0] opc;
    logic       opc_legal;
    assign opc = dinst_q[6:2];

    always_comb begin
        opc_legal = 1'b0;
        dimm      = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                opc_legal = 1'b1;
                dimm      = {dinst_q[31:12], 12'h000};
            end
            OPC_JAL: begin
                opc_legal = 1'b1;
                dimm      = {{12{dinst_q[31]}}, dinst_q[19:12], dinst_q[20], dinst_q[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISC, OPC_SYSTEM: begin
                opc_legal = 1'b1;
                dimm      = {{20{dinst_q[31]}}, dinst_q[31:20]};
            end
            OPC_BRANCH: begin
                opc_legal = 1'b1;
                dimm      = {{20{dinst_q[31]}}, dinst_q[7], dinst_q[30:25], dinst_q[11:8], 1'b0};
            end
            OPC_STORE: begin
                opc_legal = 1'b1;
                dimm      = {{20{dinst_q[31]}}, dinst_q[31:25], dinst_q[11:7]};
            end
            OPC_OP: begin
                opc_legal = 1'b1;
            end
            default: begin
                opc_legal = 1'b0;
            end
        endcase
    end

    assign dinst = dinst_q;
    assign dpc   = dpc_q;
    assign dtag  = dtag_q;
    assign dvld  = dvld_q;
    assign dill  = dvld_q & ((dinst_q[1:0] != 2'b11) | ~opc_legal);
    assign dopc  = opc;
    assign dfn3  = dinst_q[14:12];
    assign dfn7  = dinst_q[30];
    assign drd   = dinst_q[11:7];
    assign drs1  = dinst_q[19:15];
    assign drs2  = dinst_q[24:20];

endmodule

// File: tb/tb_t5_ifetch_dec.sv
// Directed bench for t5_ifetch_dec: reset, decode/immediate sweep, skid and reset-discard scenarios.
module tb_t5_ifetch_dec;

    logic        sclk = 1'b0;
    logic        srst, sena, iwb_ack;
    logic [31:0] fpc, iwb_dat;
    logic [31:0] dinst, dimm;
    logic [29:0] dpc;
    logic [1:0]  dtag;
    logic        dvld, dill, dfn7;
    logic [4:0]  dopc, drd, drs1, drs2;
    logic [2:0]  dfn3;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 sclk = ~sclk;

    t5_ifetch_dec dut (
        .sclk(sclk), .srst(srst), .sena(sena), .fpc(fpc),
        .iwb_dat(iwb_dat), .iwb_ack(iwb_ack),
        .dinst(dinst), .dpc(dpc), .dtag(dtag), .dvld(dvld), .dill(dill),
        .dopc(dopc), .dfn3(dfn3), .dfn7(dfn7),
        .drd(drd), .drs1(drs1), .drs2(drs2), .dimm(dimm)
    );

    // Apply inputs, pass one rising edge, then sample 1 time unit later.
    task automatic step(input logic r, input logic en, input logic ack,
                        input logic [31:0] dat, input logic [31:0] pc);
        srst = r; sena = en; iwb_ack = ack; iwb_dat = dat; fpc = pc;
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        total_cnt++; if (dinst !== 32'h13) $display("FAIL reset_dinst got %h exp %h", dinst, 32'h13); else pass_cnt++;
        total_cnt++; if (dopc !== 5'b00100) $display("FAIL reset_dopc got %b exp 00100", dopc); else pass_cnt++;
        total_cnt++; if (dvld !== 1'b0) $display("FAIL reset_dvld got %b exp 0", dvld); else pass_cnt++;
        total_cnt++; if (dill !== 1'b0) $display("FAIL reset_dill got %b exp 0", dill); else pass_cnt++;
        total_cnt++; if (dimm !== 32'h0) $display("FAIL reset_dimm got %h exp 0", dimm); else pass_cnt++;
        total_cnt++; if (dpc !== 30'h0 || dtag !== 2'd0) $display("FAIL reset_pc got %h/%0d exp 0/0", dpc, dtag); else pass_cnt++;
        total_cnt++; if ({drd, drs1, drs2, dfn3, dfn7} !== 19'h0) $display("FAIL reset_fields got %h exp 0", {drd, drs1, drs2, dfn3, dfn7}); else pass_cnt++;
    endtask

    task automatic test_bubble();
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0102);
        total_cnt++; if (dinst !== 32'h13) $display("FAIL bubble_dinst got %h exp 00000013", dinst); else pass_cnt++;
        total_cnt++; if (dvld !== 1'b0) $display("FAIL bubble_dvld got %b exp 0", dvld); else pass_cnt++;
        total_cnt++; if (dpc !== 30'h40) $display("FAIL bubble_dpc got %h exp 40", dpc); else pass_cnt++;
        total_cnt++; if (dtag !== 2'd2) $display("FAIL bubble_dtag got %0d exp 2", dtag); else pass_cnt++;
    endtask

    task automatic test_addi();
        step(1'b0, 1'b1, 1'b1, 32'hFFF1_0093, 32'h0000_0203);
        total_cnt++; if (dvld !== 1'b1 || dill !== 1'b0) $display("FAIL addi_vld_ill got %b%b exp 10", dvld, dill); else pass_cnt++;
        total_cnt++; if (dopc !== 5'b00100) $display("FAIL addi_dopc got %b exp 00100", dopc); else pass_cnt++;
        total_cnt++; if (drd !== 5'd1 || drs1 !== 5'd2) $display("FAIL addi_regs got rd=%0d rs1=%0d exp 1 2", drd, drs1); else pass_cnt++;
        total_cnt++; if (dimm !== 32'hFFFF_FFFF) $display("FAIL addi_dimm got %h exp ffffffff", dimm); else pass_cnt++;
        total_cnt++; if (dpc !== 30'h80 || dtag !== 2'd3) $display("FAIL addi_pc got %h/%0d exp 80/3", dpc, dtag); else pass_cnt++;
    endtask

    task automatic test_imm_sweep();
        step(1'b0, 1'b1, 1'b1, 32'hFE00_0EE3, 32'h0000_0100);
        total_cnt++; if (dimm !== 32'hFFFF_FFFC) $display("FAIL beq_dimm got %h exp fffffffc", dimm); else pass_cnt++;
        total_cnt++; if (dopc !== 5'b11000 || dill !== 1'b0) $display("FAIL beq_opc got %b/%b exp 11000/0", dopc, dill); else pass_cnt++;
        step(1'b0, 1'b1, 1'b1, 32'h1234_50B7, 32'h0000_0100);
        total_cnt++; if (dimm !== 32'h1234_5000) $display("FAIL lui_dimm got %h exp 12345000", dimm); else pass_cnt++;
        total_cnt++; if (drd !== 5'd1) $display("FAIL lui_drd got %0d exp 1", drd); else pass_cnt++;
        step(1'b0, 1'b1, 1'b1, 32'h0000_006F, 32'h0000_0100);
        total_cnt++; if (dimm !== 32'h0 || dopc !== 5'b11011) $display("FAIL jal_dimm got %h/%b exp 0/11011", dimm, dopc); else pass_cnt++;
        step(1'b0, 1'b1, 1'b1, 32'hFE11_2E23, 32'h0000_0100);
        total_cnt++; if (dimm !== 32'hFFFF_FFFC) $display("FAIL sw_dimm got %h exp fffffffc", dimm); else pass_cnt++;
        total_cnt++; if (drs2 !== 5'd1 || dfn3 !== 3'd2) $display("FAIL sw_fields got rs2=%0d fn3=%0d exp 1 2", drs2, dfn3); else pass_cnt++;
    endtask

    task automatic test_illegal();
        step(1'b0, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0100);
        total_cnt++; if (dill !== 1'b1 || dvld !== 1'b1) $display("FAIL ill_opc got ill=%b vld=%b exp 1 1", dill, dvld); else pass_cnt++;
        total_cnt++; if (dimm !== 32'h0) $display("FAIL ill_dimm got %h exp 0", dimm); else pass_cnt++;
        step(1'b0, 1'b1, 1'b1, 32'h0000_0012, 32'h0000_0100);
        total_cnt++; if (dill !== 1'b1) $display("FAIL ill_lowbits got %b exp 1", dill); else pass_cnt++;
    endtask

    task automatic test_skid();
        step(1'b0, 1'b0, 1'b1, 32'h0020_8033, 32'h0000_0FFF);
        total_cnt++; if (dinst !== 32'h0000_0012 || dvld !== 1'b1) $display("FAIL skid_hold got %h/%b exp 00000012/1", dinst, dvld); else pass_cnt++;
        total_cnt++; if (dpc !== 30'h40 || dtag !== 2'd0) $display("FAIL skid_hold_pc got %h/%0d exp 40/0", dpc, dtag); else pass_cnt++;
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0305);
        total_cnt++; if (dinst !== 32'h0020_8033 || dvld !== 1'b1) $display("FAIL skid_drain got %h/%b exp 00208033/1", dinst, dvld); else pass_cnt++;
        total_cnt++; if (dopc !== 5'b01100 || dimm !== 32'h0 || dill !== 1'b0) $display("FAIL skid_op_dec got %b/%h/%b exp 01100/0/0", dopc, dimm, dill); else pass_cnt++;
        total_cnt++; if (dpc !== 30'hC1 || dtag !== 2'd1) $display("FAIL skid_drain_pc got %h/%0d exp c1/1", dpc, dtag); else pass_cnt++;
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100);
        total_cnt++; if (dinst !== 32'h13 || dvld !== 1'b0) $display("FAIL skid_empty got %h/%b exp 00000013/0", dinst, dvld); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 1'b1, 32'h0010_0093, 32'h0000_0100);
        step(1'b0, 1'b1, 1'b1, 32'h0020_0113, 32'h0000_0100);
        total_cnt++; if (dinst !== 32'h0010_0093 || dimm !== 32'h1) $display("FAIL b2b_a got %h/%h exp 00100093/1", dinst, dimm); else pass_cnt++;
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100);
        total_cnt++; if (dinst !== 32'h0020_0113 || dvld !== 1'b1 || drd !== 5'd2) $display("FAIL b2b_b got %h/%b/%0d exp 00200113/1/2", dinst, dvld, drd); else pass_cnt++;
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100);
        total_cnt++; if (dvld !== 1'b0) $display("FAIL b2b_after got %b exp 0", dvld); else pass_cnt++;
    endtask

    task automatic test_reset_discard();
        step(1'b0, 1'b0, 1'b1, 32'h0010_0093, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b1, 32'h0020_0113, 32'h0000_0100);
        total_cnt++; if (dinst !== 32'h13 || dvld !== 1'b0 || dpc !== 30'h0) $display("FAIL rst_mid got %h/%b/%h exp 00000013/0/0", dinst, dvld, dpc); else pass_cnt++;
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100);
        total_cnt++; if (dinst !== 32'h13 || dvld !== 1'b0) $display("FAIL rst_discard got %h/%b exp 00000013/0", dinst, dvld); else pass_cnt++;
    endtask

    initial begin
        srst = 1'b1; sena = 1'b0; iwb_ack = 1'b0; iwb_dat = '0; fpc = '0;
        test_reset();
        test_bubble();
        test_addi();
        test_imm_sweep();
        test_illegal();
        test_skid();
        test_back_to_back();
        test_reset_discard();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
